// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package alu_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_nibble_seq_ripple_adder.sv
// Ripple_adder: 4-bit combinational ripple-carry adder, the only arithmetic in the sequencer.
module Ripple_adder
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] sum_o,
  output logic             cout_o
);

  logic c;

  // One full adder per bit, carry rippling LSB to MSB.
  always_comb begin
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < int'(NIB_W); i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a single Ripple_adder.
// Subtraction is built only when ALU_NIBBLE_SEQ_SUB_EN is defined; otherwise op_sub is ignored.
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   b_eff;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [NIB_W-1:0]   a_nib, b_nib, sum_nib;
  logic               cout_nib;
  logic               last_nib;

`ifdef ALU_NIBBLE_SEQ_SUB_EN
  logic sub_q, sub_d;
  assign b_eff = sub_q ? ~b_q : b_q;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign b_eff         = b_q;
`endif

  assign a_nib    = a_q[int'(idx_q)*int'(NIB_W) +: NIB_W];
  assign b_nib    = b_eff[int'(idx_q)*int'(NIB_W) +: NIB_W];
  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  Ripple_adder u_adder (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .sum_o  (sum_nib),
    .cout_o (cout_nib)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
`ifdef ALU_NIBBLE_SEQ_SUB_EN
    sub_d    = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          idx_d   = '0;
`ifdef ALU_NIBBLE_SEQ_SUB_EN
          sub_d   = op_sub;
          carry_d = op_sub | cin;
`else
          carry_d = cin;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[int'(idx_q)*int'(NIB_W) +: NIB_W] = sum_nib;
        carry_d = cout_nib;
        if (last_nib) begin
          cout_d  = cout_nib;
          ovf_d   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum_nib[NIB_W-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_NIBBLE_SEQ_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
`ifdef ALU_NIBBLE_SEQ_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign result      = result_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboard bench for alu_nibble_seq (WIDTH = 16) against an integer-arithmetic reference model.
module tb_alu_nibble_seq;

  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] op_a, op_b;
  logic        cin, op_sub;
  logic        res_valid, res_ready;
  logic [15:0] result;
  logic        cout, ovf, busy;

  alu_nibble_seq #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
    .op_sub      (op_sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   seen   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on whole operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
    exp_t e;
    int   ua, ub, sa, sb, u, sv;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
`ifndef ALU_NIBBLE_SEQ_SUB_EN
    s = 1'b0;
`endif
    if (s) begin
      u    = ua - ub;
      sv   = sa - sb;
      e.co = (ua >= ub);
    end else begin
      u    = ua + ub + int'(c);
      sv   = sa + sb + int'(c);
      e.co = (u > 65535);
    end
    e.r   = 16'(u);
    e.ov  = (sv > 32767) || (sv < -32768);
    e.acc = 0;
    return e;
  endfunction

  // Monitor: latency on first sight of res_valid, payload on handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got result %0h with no request pending", result);
        end else begin
          chk("latency", 32'(cyc - q[0].acc), 32'(NIB));
        end
      end
      if (res_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("result", 32'(result), 32'(e.r));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf", 32'(ovf), 32'(e.ov));
        seen = 1'b0;
      end else if (res_ready) begin
        seen = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input bit push);
    int   n = 0;
    exp_t e;
    while (!start_ready && n < 100) begin
      step();
      n++;
    end
    if (!start_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: start_ready stuck at %0b, required 1", start_ready);
      return;
    end
    op_a = a; op_b = b; cin = c; op_sub = s;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom);
    cin = 1'($urandom); op_sub = 1'($urandom);
    if (push) begin
      e     = model(a, b, c, s);
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    chk("wait_res_valid", 32'(res_valid), 32'(1));
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
    op_a = '0; op_b = '0; cin = 1'b0; op_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", 32'(start_ready), 32'(1));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    rst_n = 1'b1;
    step();

    // Directed cases
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    issue(16'h0000, 16'h0000, 1'b1, 1'b0, 1);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1);
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
    issue(16'h8000, 16'h0001, 1'b1, 1'b1, 1);
    issue(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 1);

    // Backpressure: result held, new request ignored
    wait_valid();
    step();
    res_ready = 1'b0;
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
    e = model(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      chk("bp_start_ready", 32'(start_ready), 32'(0));
      chk("bp_res_valid", 32'(res_valid), 32'(1));
      chk("bp_result", 32'(result), 32'(e.r));
      chk("bp_cout", 32'(cout), 32'(e.co));
      chk("bp_ovf", 32'(ovf), 32'(e.ov));
      if (i == 2) begin
        op_a = 16'hAAAA; op_b = 16'h5555; start_valid = 1'b1;
      end
      step();
      start_valid = 1'b0;
    end
    res_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(res_valid), 32'(0));
    chk("bp_release_ready", 32'(start_ready), 32'(1));
    repeat (8) step();

    // Reset two cycles into RUN with a pending carry
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", 32'(result), 32'(0));
    chk("mid_rst_cout", 32'(cout), 32'(0));
    chk("mid_rst_ovf", 32'(ovf), 32'(0));
    chk("mid_rst_res_valid", 32'(res_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_start_ready", 32'(start_ready), 32'(1));
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_start_ready", 32'(start_ready), 32'(1));
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
      repeat ($urandom_range(0, 2)) step();
    end

    begin
      int n = 0;
      while (q.size() != 0 && n < 200) begin
        step();
        n++;
      end
      repeat (10) step();
      chk("queue_drained", 32'(q.size()), 32'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Multi-precision add/subtract sequencer built around the team's 4-bit `Ripple_adder`. It accepts WIDTH-bit operands over a valid/ready handshake and feeds them through a single 4-bit adder instance one nibble per cycle, LSB first, registering the carry between nibbles. It returns the WIDTH-bit result with carry-out and signed overflow on a second handshake, so one adder serves any operand width.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥4; NIB = WIDTH/4
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  operation request
- start_ready  out  1  block can accept; equals (state == IDLE)
- op_a  in  WIDTH  operand A, sampled on acceptance only
- op_b  in  WIDTH  operand B, sampled on acceptance only
- cin  in  1  carry-in for add; sampled on acceptance
- op_sub  in  1  1 = A − B; sampled on acceptance; see Configuration
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference, registered
- cout  out  1  final carry-out (for subtract, 1 = no borrow)
- ovf  out  1  two's-complement overflow
- busy  out  1  state != IDLE

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: start_ready = 1. When start_valid && start_ready at an edge, the block latches op_a, op_b, cin and op_sub, clears nib_idx to 0 and moves to RUN.
- Latched carry: cin for add; 1 for subtract, with cin ignored.
- RUN: the adder gets A = a_reg[4k+3:4k] and B = b_eff[4k+3:4k], where b_eff = op_sub ? ~b_reg : b_reg. Cin comes from carry_reg.
  - Each edge writes the sum nibble into result[4k+3:4k], updates carry_reg with the adder Cout, and increments nib_idx.
  - After the edge that processes nibble NIB−1, the block moves to DONE. cout ← final Cout, and ovf ← (a_reg[MSB] == b_eff[MSB]) && (sum[MSB] != a_reg[MSB]).
- DONE: res_valid = 1. result, cout and ovf hold stable until res_valid && res_ready at an edge, then the block returns to IDLE.
- start_valid is ignored outside IDLE; no queueing. Operand inputs may change freely after acceptance.
- nib_idx width is clog2(NIB), minimum 1. nib_idx never wraps inside an operation; it is cleared on every acceptance.
- Reset (any state, including mid-RUN) aborts the operation immediately:
  - state = IDLE, result = 0, cout = 0, ovf = 0, res_valid = 0, busy = 0, carry_reg = 0, nib_idx = 0.
  - start_ready = 1 while in reset and after release.
  - A partial result is never presented.

## Timing
- Acceptance edge E0. Nibble k is captured at edge E(k+1).
- res_valid rises after edge E(NIB), i.e. NIB cycles after acceptance (4 for WIDTH = 16).
- If res_ready is held at 1, res_valid lasts 1 cycle. start_ready is 1 in the following cycle, and the next acceptance is possible there.
- Minimum issue interval is NIB + 2 cycles.
- All outputs are registered or decoded from registered state only; there is no input-to-output combinational path.
- The combinational adder path is a single 4-bit ripple chain per cycle.

## Configuration
- Macro: ALU_NIBBLE_SEQ_SUB_EN.
- Defined: subtraction is supported as above.
- Undefined:
  - The op_sub port remains but is ignored and treated as 0. The b_eff inversion mux is not built.
  - cin is always used as the initial carry.
  - ovf still reports add overflow.

## Structure
- Shared package alu_pkg holds:
  - state encoding constants: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
  - NIB_W = 4
- One sub-module: a single `Ripple_adder` instance for the nibble datapath.
- FSM, operand registers, nibble mux and result write-back live in alu_nibble_seq.

## Test plan
All cases use WIDTH = 16.
- Add 0x1234 + 0x4321, cin = 0 → result 0x5555, cout 0, ovf 0. res_valid asserted exactly 4 cycles after the acceptance edge.
- Add 0xFFFF + 0x0001, cin = 0 → result 0x0000, cout 1, ovf 0 (carry ripples through all 4 nibbles). Also: 0x0000 + 0x0000, cin = 1 → 0x0001.
- Add 0x7FFF + 0x0001 → result 0x8000, cout 0, ovf 1. Add 0x8000 + 0x8000 → 0x0000, cout 1, ovf 1.
- With ALU_NIBBLE_SEQ_SUB_EN:
  - 0x0005 − 0x0007 → 0xFFFE, cout 0, ovf 0.
  - 0x8000 − 0x0001 → 0x7FFF, cout 1, ovf 1.
  - Without the macro, op_sub = 1 gives a plain add.
- Backpressure: hold res_ready = 0 for 6 cycles and pulse start_valid with new operands → result/cout/ovf stable, start_ready 0, new request ignored. Release res_ready → return to IDLE in 1 cycle.
- Assert rst_n low 2 cycles into RUN → all outputs 0 and start_ready 1 during reset. After release, 0x00FF + 0x0001 yields 0x0100 with no stale carry.
